// File: rtl/univ_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_pkg
//  Description : Shared types and helpers for the N-bit universal shift
//                register: operation codes, serializer states and the
//                shift-amount width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package univ_shift_pkg;

    // Operation select, applied in IDLE on enabled edges
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SHR  = 3'd1,
        SHL  = 3'd2,
        LOAD = 3'd3,
        ROR  = 3'd4,
        ROL  = 3'd5,
        SAR  = 3'd6,
        SER  = 3'd7
    } op_e;

    // Serializer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of the shift-amount bus for an N-bit register (N >= 2)
    function automatic int amt_w(input int n);
        return $clog2(n);
    endfunction

endpackage : univ_shift_pkg
`default_nettype wire

// File: rtl/barrel_shift.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift
//  Description : Combinational N-bit barrel unit. Produces the shifted or
//                rotated value for SHR/SHL/ROR/ROL/SAR and the single bit
//                that leaves the register. Other ops pass the value through.
//                The amount is taken modulo N so non-power-of-two widths
//                stay well defined for out-of-range inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift
    import univ_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          value,
    input  logic [amt_w(N)-1:0]   amt,
    input  logic [2:0]            op,
    input  logic                  sin,
    output logic [N-1:0]          result,
    output logic                  out_bit
);

    // Effective amount in the range 0..N-1
    int              w_amt_i;
    // Double-width work vector: fill bits sit beside the value so a single
    // logical shift yields the result for every mode
    logic [2*N-1:0]  w_wide;
    logic            w_is_right;
    logic            w_is_left;

    // Reduce the requested amount modulo the register width
    always_comb begin
        w_amt_i = int'(amt) % N;
    end

    // Classify the operation by the direction bits leave the register
    always_comb begin
        w_is_right = 1'b0;
        w_is_left  = 1'b0;
        case (op_e'(op))
            SHR, ROR, SAR: w_is_right = 1'b1;
            SHL, ROL:      w_is_left  = 1'b1;
            default:       ;
        endcase
    end

    // Build the result from a double-width shift with mode-specific fill
    always_comb begin
        w_wide = '0;
        result = value;
        case (op_e'(op))
            SHR: begin
                w_wide = {{N{sin}}, value} >> w_amt_i;
                result = w_wide[N-1:0];
            end
            SHL: begin
                w_wide = {value, {N{sin}}} << w_amt_i;
                result = w_wide[2*N-1:N];
            end
            ROR: begin
                w_wide = {value, value} >> w_amt_i;
                result = w_wide[N-1:0];
            end
            ROL: begin
                w_wide = {value, value} << w_amt_i;
                result = w_wide[2*N-1:N];
            end
            SAR: begin
                w_wide = {{N{value[N-1]}}, value} >> w_amt_i;
                result = w_wide[N-1:0];
            end
            default: result = value;
        endcase
    end

    // Select the last bit to leave: value[amt-1] going right, value[N-amt]
    // going left; nothing leaves when the amount is zero
    always_comb begin
        out_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_is_right && (w_amt_i == i + 1)) begin
                out_bit = value[i];
            end
            if (w_is_left && (w_amt_i != 0) && (w_amt_i == N - i)) begin
                out_bit = value[i];
            end
        end
    end

endmodule : barrel_shift
`default_nettype wire

// File: rtl/univ_shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg_n
//  Description : Parametrised N-bit universal shift register with barrel
//                shifts, rotates, arithmetic shift, parallel load, clock
//                enable, shifted-out bit reporting and an MSB-first
//                serializer (busy / one-cycle done pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg_n
    import univ_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            op,
    input  logic [amt_w(N)-1:0]   amt,
    input  logic [N-1:0]          din,
    input  logic                  sin,
    output logic [N-1:0]          dout,
    output logic                  sout,
    output logic                  busy,
    output logic                  done
);

    localparam int              c_aw   = amt_w(N);
    // Counter value on the edge that presents the final serial bit
    localparam logic [c_aw-1:0] c_last = c_aw'(N - 1);

    state_e            r_state;
    logic [N-1:0]      r_dout;
    logic              r_sout;
    logic              r_busy;
    logic              r_done;
    logic [c_aw-1:0]   r_cnt;

    logic [N-1:0]      w_result;
    logic              w_out_bit;
    logic              w_amt_zero;

    barrel_shift #(
        .N       (N)
    ) u_barrel (
        .value   (r_dout),
        .amt     (amt),
        .op      (op),
        .sin     (sin),
        .result  (w_result),
        .out_bit (w_out_bit)
    );

    // A zero effective amount leaves both the register and sout untouched
    assign w_amt_zero = ((int'(amt) % N) == 0);

    // Register, shifted-out bit and serializer FSM; done self-clears every
    // non-reset cycle so it can only ever be a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dout  <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                case (r_state)
                    IDLE: begin
                        case (op_e'(op))
                            HOLD: ;
                            LOAD: r_dout <= din;
                            SER: begin
                                r_dout  <= din;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= SHIFT;
                            end
                            SHR, SHL, ROR, ROL, SAR: begin
                                if (!w_amt_zero) begin
                                    r_dout <= w_result;
                                    r_sout <= w_out_bit;
                                end
                            end
                            default: ;
                        endcase
                    end
                    SHIFT: begin
                        // op and amt are ignored while serializing
                        r_dout <= {r_dout[N-2:0], sin};
                        if (r_cnt == c_last) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_aw'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign dout = r_dout;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule : univ_shift_reg_n
`default_nettype wire

// File: tb/tb_univ_shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_univ_shift_reg_n
//  Description : Self-checking bench for univ_shift_reg_n (N=8). A word-level
//                arithmetic model tracks the expected outputs; directed
//                vectors pin it with hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg_n;
    import univ_shift_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   op;
    logic [2:0]   amt;
    logic [7:0]   din;
    logic         sin;
    logic [7:0]   dout;
    logic         sout;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Reference model state
    logic [7:0] m_dout = 8'h00;
    logic       m_sout = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_rem  = 0;

    univ_shift_reg_n #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .op   (op),
        .amt  (amt),
        .din  (din),
        .sin  (sin),
        .dout (dout),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: shifts as integer arithmetic, serializer as a
    // count of bits still to present
    task automatic model_step();
        int dv;
        int a;
        int r;
        int ob;
        if (rst) begin
            m_dout = 8'h00; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
            return;
        end
        m_done = 1'b0;
        if (!en) return;
        dv = int'(m_dout);
        if (m_busy) begin
            m_dout = 8'((dv * 2 + int'(sin)) % 256);
            m_rem  = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            return;
        end
        a  = int'(amt);
        r  = dv;
        ob = int'(m_sout);
        case (op_e'(op))
            LOAD: r = int'(din);
            SER: begin
                r = int'(din); m_rem = 8; m_busy = 1'b1;
            end
            SHR: if (a != 0) begin
                r  = (dv >> a) | (sin ? ((255 << (8 - a)) & 255) : 0);
                ob = (dv >> (a - 1)) & 1;
            end
            SHL: if (a != 0) begin
                r  = ((dv << a) | (sin ? ((1 << a) - 1) : 0)) & 255;
                ob = (dv >> (8 - a)) & 1;
            end
            ROR: if (a != 0) begin
                r  = ((dv >> a) | (dv << (8 - a))) & 255;
                ob = (dv >> (a - 1)) & 1;
            end
            ROL: if (a != 0) begin
                r  = ((dv << a) | (dv >> (8 - a))) & 255;
                ob = (dv >> (8 - a)) & 1;
            end
            SAR: if (a != 0) begin
                r  = (dv >= 128) ? (((dv - 256) >>> a) & 255) : (dv >> a);
                ob = (dv >> (a - 1)) & 1;
            end
            default: ;
        endcase
        m_dout = 8'(r);
        m_sout = ob[0];
    endtask

    always @(posedge clk) model_step();

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mdl_dout", 32'(dout), 32'(m_dout));
            chk("mdl_sout", 32'(sout), 32'(m_sout));
            chk("mdl_busy", 32'(busy), 32'(m_busy));
            chk("mdl_done", 32'(done), 32'(m_done));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] o,
                       input logic [2:0] a, input logic [7:0] d, input logic s);
        @(negedge clk);
        rst = r; en = e; op = o; amt = a; din = d; sin = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] got;
        int         nbits;
        int         guard;
        int         stalls;
        logic [7:0] snap;

        rst = 1'b1; en = 1'b0; op = 3'd0; amt = 3'd0; din = 8'h00; sin = 1'b0;

        // Reset with random op/din
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
            cmp_on = 1'b1;
        end
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_sout", 32'(sout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // LOAD, SHR with sin fill, zero-amount SHL
        cyc(1'b0, 1'b1, LOAD, 3'd0, 8'hB4, 1'b0);
        chk("load_b4", 32'(dout), 32'hB4);
        cyc(1'b0, 1'b1, SHR, 3'd3, 8'h00, 1'b1);
        chk("shr3_dout", 32'(dout), 32'hF6);
        chk("shr3_sout", 32'(sout), 32'h1);
        cyc(1'b0, 1'b1, SHL, 3'd0, 8'h00, 1'b0);
        chk("shl0_dout", 32'(dout), 32'hF6);
        chk("shl0_sout", 32'(sout), 32'h1);

        // SAR / ROL / ROR
        cyc(1'b0, 1'b1, LOAD, 3'd0, 8'h96, 1'b0);
        cyc(1'b0, 1'b1, SAR, 3'd2, 8'h00, 1'b0);
        chk("sar2_dout", 32'(dout), 32'hE5);
        chk("sar2_sout", 32'(sout), 32'h1);
        cyc(1'b0, 1'b1, LOAD, 3'd0, 8'h96, 1'b0);
        cyc(1'b0, 1'b1, ROL, 3'd3, 8'h00, 1'b1);
        chk("rol3_dout", 32'(dout), 32'hB4);
        chk("rol3_sout", 32'(sout), 32'h0);
        cyc(1'b0, 1'b1, ROR, 3'd4, 8'h00, 1'b1);
        chk("ror4_dout", 32'(dout), 32'h4B);
        chk("ror4_sout", 32'(sout), 32'h0);

        // Plain serialization of A5
        cyc(1'b0, 1'b1, SER, 3'd0, 8'hA5, 1'b0);
        got = 8'h00; nbits = 0; guard = 0;
        while (busy && guard < 40) begin
            got = {got[6:0], dout[7]};
            nbits++;
            chk("ser_a5_nodone", 32'(done), 32'h0);
            cyc(1'b0, 1'b1, HOLD, 3'd0, 8'h00, 1'b0);
            guard++;
        end
        chk("ser_a5_timeout", 32'(guard < 40), 32'h1);
        chk("ser_a5_bits", 32'(got), 32'hA5);
        chk("ser_a5_count", 32'(nbits), 32'd8);
        chk("ser_a5_done", 32'(done), 32'h1);
        chk("ser_a5_final", 32'(dout), 32'h00);
        // New op accepted in the done cycle
        cyc(1'b0, 1'b1, LOAD, 3'd0, 8'h5A, 1'b0);
        chk("done_clear", 32'(done), 32'h0);
        chk("load_after_done", 32'(dout), 32'h5A);

        // Serialization of C3 with a stall and LOAD requests during busy
        cyc(1'b0, 1'b1, SER, 3'd0, 8'hC3, 1'b0);
        got = 8'h00; nbits = 0; guard = 0; stalls = 0;
        while (busy && guard < 40) begin
            if (nbits == 2 && stalls < 3) begin
                snap = dout;
                cyc(1'b0, 1'b0, LOAD, 3'd0, 8'hFF, 1'b1);
                chk("stall_dout", 32'(dout), 32'(snap));
                chk("stall_busy", 32'(busy), 32'h1);
                stalls++;
            end else begin
                got = {got[6:0], dout[7]};
                nbits++;
                cyc(1'b0, 1'b1, LOAD, 3'd0, 8'hFF, 1'b0);
            end
            guard++;
        end
        chk("ser_c3_timeout", 32'(guard < 40), 32'h1);
        chk("ser_c3_bits", 32'(got), 32'hC3);
        chk("ser_c3_count", 32'(nbits), 32'd8);
        chk("ser_c3_done", 32'(done), 32'h1);
        chk("ser_c3_final", 32'(dout), 32'h00);
        cyc(1'b0, 1'b1, HOLD, 3'd0, 8'h00, 1'b0);
        chk("ser_c3_single_done", 32'(done), 32'h0);

        // Serialization of FF aborted by reset after the 4th bit
        cyc(1'b0, 1'b1, SER, 3'd0, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, HOLD, 3'd0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, SER, 3'd0, 8'hAA, 1'b1);
        chk("abort_dout", 32'(dout), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, HOLD, 3'd0, 8'h00, 1'b0);
            chk("abort_no_done", 32'(done), 32'h0);
        end

        // Random traffic, checked every cycle against the model
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_univ_shift_reg_n
`default_nettype wire
